imm_load_expander: RTL and testbench
====================================

Name: imm_load_expander

Overview:
- Inverse of the datapath immediate sign-extension path: takes a 32-bit constant plus a destination register and emits the shortest MIPS instruction sequence that loads that constant into the register.
- Output is 1 or 2 32-bit instructions (ADDI / ORI / LUI / LUI+ORI).
- Sits between the test-program generator (or `li` pseudo-op front end) and instruction memory fill logic.
- Valid/ready handshake on both sides; sequential FSM handles the two-instruction case.

Parameters:
- OP_ADDI, 6'b001000, opcode used for the signed-16 case
- OP_ORI, 6'b001101, opcode for the OR-immediate
- OP_LUI, 6'b001111, opcode for load-upper-immediate
- CNT_W, 16, width of the emitted-instruction counter

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- req_valid_i  in  1  request present
- req_ready_o  out  1  block can accept a request
- rt_i  in  5  destination register number
- value_i  in  32  constant to load
- instr_valid_o  out  1  instr_o holds a valid instruction
- instr_ready_i  in  1  consumer takes instr_o this cycle
- instr_o  out  32  emitted instruction word
- last_o  out  1  instr_o is the final instruction of the current request
- instr_cnt_o  out  CNT_W  total instructions handed off since reset
- err_o  out  1  sticky reconstruction mismatch (see Optional Feature)

Behaviour:
- Reset values while rst_i is high: state=IDLE, req_ready_o=1, instr_valid_o=0, instr_o=0, last_o=0, instr_cnt_o=0, err_o=0.
- Reset asserted mid-operation aborts any pending instruction. Nothing further is emitted for that request.
- States:
  - IDLE: req_ready_o=1.
  - EMIT1: presents the first or only instruction.
  - EMIT2: presents the ORI of a LUI+ORI pair.
  - req_ready_o=0 outside IDLE.
- Accept: req_valid_i && req_ready_o at edge N. rt_i and value_i are registered.
- If rt_i==0, the request is dropped: state stays IDLE, nothing is emitted, and the counter is unchanged.
- Classification, with hi=value[31:16] and lo=value[15:0]:
  - value[31:15] all equal → single ADDI: {OP_ADDI, 5'd0, rt, lo}.
  - else hi==0 → single ORI: {OP_ORI, 5'd0, rt, lo}.
  - else lo==0 → single LUI: {OP_LUI, 5'd0, rt, hi}.
  - else → LUI {OP_LUI, 5'd0, rt, hi} followed by ORI {OP_ORI, rt, rt, lo}.
- Latency: instr_valid_o rises at N+1 with EMIT1 contents.
- last_o=1 in EMIT1 for single-instruction cases. last_o=1 in EMIT2.
- Handoff happens when instr_valid_o && instr_ready_i at an edge:
  - EMIT1 goes to EMIT2 if a pair is in progress, else to IDLE.
  - EMIT2 goes to IDLE.
  - instr_cnt_o increments by 1 per handoff and wraps modulo 2^CNT_W.
- Backpressure: while instr_valid_o && !instr_ready_i, instr_o and last_o hold stable and the state does not advance.
- Return to IDLE: instr_valid_o drops in the cycle after the final handoff. req_ready_o is 1 that cycle. No accept in the same cycle as a handoff.
- instr_ready_i is ignored while instr_valid_o=0.

Optional Feature:
- Macro: IMM_LOAD_EXPANDER_CHECK_EN.
- When defined:
  - An internal shadow register models rt after each handoff: ADDI = sign-extended lo; ORI with rs=0 = zero-extended lo; LUI = {hi,16'b0}; ORI with rs=rt = shadow | {16'b0,lo}.
  - On the last handoff, if shadow != registered value, err_o sets.
  - err_o is sticky until reset.
- When undefined: the shadow logic is absent and err_o is tied to 0.

Test Plan:
- rt=8, value=0xFFFFFFFC → one instr 0x2008FFFC, last_o=1 at N+1, instr_cnt_o=1.
- rt=11, value=0x00008000 → one instr 0x340B8000 (ORI, not ADDI).
- rt=9, value=0x00010000 → one instr 0x3C090001.
- rt=10, value=0x12345678, instr_ready_i held low 3 cycles during EMIT2 → 0x3C0A1234 (last_o=0), then 0x354A5678 held stable during the stall, last_o=1, instr_cnt_o +2, err_o=0 with macro.
- rt=0, value=0x12345678 → no instr_valid_o, req_ready_o stays 1, instr_cnt_o unchanged.
- rt=10, value=0x12345678, rst_i pulsed during EMIT2 → all outputs at reset values immediately, no ORI emitted, next request processed normally.

Source files
------------

// File: rtl/imm_load_expander_if.sv
// rtl/imm_load_expander_if.sv - request/instruction handshake bundle for imm_load_expander
interface imm_load_expander_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [4:0]  rt_i;
    logic [31:0] value_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic        last_o;

    // Block side: consumes requests, produces instructions
    modport slave (
        input  req_valid_i, rt_i, value_i, instr_ready_i,
        output req_ready_o, instr_valid_o, instr_o, last_o
    );

    // Producer/consumer side as seen by the surrounding logic
    modport master (
        output req_valid_i, rt_i, value_i, instr_ready_i,
        input  req_ready_o, instr_valid_o, instr_o, last_o
    );
endinterface

// File: rtl/imm_load_expander.sv
// rtl/imm_load_expander.sv - expands a 32-bit constant into ADDI/ORI/LUI/LUI+ORI (optional IMM_LOAD_EXPANDER_CHECK_EN)
module imm_load_expander #(
    parameter logic [5:0] OP_ADDI = 6'b001000,
    parameter logic [5:0] OP_ORI  = 6'b001101,
    parameter logic [5:0] OP_LUI  = 6'b001111,
    parameter int         CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    imm_load_expander_if.slave bus,
    output logic [CNT_W-1:0] instr_cnt_o,
    output logic             err_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EMIT1 = 2'd1,
        S_EMIT2 = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [4:0]       r_rt;
    logic [31:0]      r_value;
    logic [CNT_W-1:0] r_cnt;

    logic             w_accept;
    logic             w_handoff;
    logic             w_sext_fits;
    logic             w_pair;
    logic [31:0]      w_instr;
    logic             w_last;
    logic             w_valid;
    logic             w_ready;

    // rt==0 requests are consumed but never leave IDLE
    assign w_accept    = bus.req_valid_i && (r_state == S_IDLE) && (bus.rt_i != 5'd0);
    assign w_handoff   = (r_state != S_IDLE) && bus.instr_ready_i;
    // Bits 31..15 all equal means the value survives a 16-bit sign-extension
    assign w_sext_fits = (r_value[31:15] == 17'h00000) || (r_value[31:15] == 17'h1ffff);
    assign w_pair      = !w_sext_fits && (r_value[31:16] != 16'h0000) && (r_value[15:0] != 16'h0000);

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: accept in IDLE, advance only on handoff
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)  w_state_next = S_EMIT1;
            S_EMIT1: if (w_handoff) w_state_next = w_pair ? S_EMIT2 : S_IDLE;
            S_EMIT2: if (w_handoff) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Outputs decoded from state and the registered request
    always_comb begin
        w_ready = 1'b0;
        w_valid = 1'b0;
        w_instr = 32'h0;
        w_last  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
            end
            S_EMIT1: begin
                w_valid = 1'b1;
                w_last  = !w_pair;
                if (w_sext_fits)
                    w_instr = {OP_ADDI, 5'd0, r_rt, r_value[15:0]};
                else if (r_value[31:16] == 16'h0000)
                    w_instr = {OP_ORI, 5'd0, r_rt, r_value[15:0]};
                else
                    w_instr = {OP_LUI, 5'd0, r_rt, r_value[31:16]};
            end
            S_EMIT2: begin
                w_valid = 1'b1;
                w_last  = 1'b1;
                w_instr = {OP_ORI, r_rt, r_rt, r_value[15:0]};
            end
            default: begin
                w_ready = 1'b0;
            end
        endcase
    end

    assign bus.req_ready_o   = w_ready;
    assign bus.instr_valid_o = w_valid;
    assign bus.instr_o       = w_instr;
    assign bus.last_o        = w_last;

    // Capture the request and count handed-off instructions
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rt    <= 5'd0;
            r_value <= 32'h0;
            r_cnt   <= '0;
        end else begin
            if (w_accept) begin
                r_rt    <= bus.rt_i;
                r_value <= bus.value_i;
            end
            if (w_handoff)
                r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign instr_cnt_o = r_cnt;

`ifdef IMM_LOAD_EXPANDER_CHECK_EN
    logic [31:0] r_shadow;
    logic [31:0] w_shadow_next;
    logic        r_err;

    // Re-execute the emitted word against a shadow copy of rt
    always_comb begin
        w_shadow_next = r_shadow;
        if (w_instr[31:26] == OP_ADDI)
            w_shadow_next = {{16{w_instr[15]}}, w_instr[15:0]};
        else if (w_instr[31:26] == OP_LUI)
            w_shadow_next = {w_instr[15:0], 16'h0000};
        else if (w_instr[25:21] == 5'd0)
            w_shadow_next = {16'h0000, w_instr[15:0]};
        else
            w_shadow_next = r_shadow | {16'h0000, w_instr[15:0]};
    end

    // Track the shadow and flag a mismatch on the final handoff
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_shadow <= 32'h0;
            r_err    <= 1'b0;
        end else if (w_handoff) begin
            r_shadow <= w_shadow_next;
            if (w_last && (w_shadow_next != r_value))
                r_err <= 1'b1;
        end
    end

    assign err_o = r_err;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_imm_load_expander.sv
// tb/tb_imm_load_expander.sv - randomized self-checking bench for imm_load_expander
module tb_imm_load_expander;

    logic        clk_i;
    logic        rst_i;
    logic [15:0] instr_cnt_o;
    logic        err_o;

    imm_load_expander_if bus ();

    imm_load_expander dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .bus         (bus.slave),
        .instr_cnt_o (instr_cnt_o),
        .err_o       (err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_pass;
    int n_total;
    int cnt_exp;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference: shortest MIPS sequence loading v into rt
    function automatic void model(input logic [4:0] rt, input logic [31:0] v);
        int signed sv;
        logic [31:0] w;
        sv = v;
        exp_q.delete();
        if (sv >= -32768 && sv <= 32767) begin
            w = (32'd8 << 26) | (32'(rt) << 16) | (v & 32'hffff);
            exp_q.push_back(w);
        end else if (v < 32'h10000) begin
            w = (32'd13 << 26) | (32'(rt) << 16) | v;
            exp_q.push_back(w);
        end else if ((v % 32'h10000) == 0) begin
            w = (32'd15 << 26) | (32'(rt) << 16) | (v / 32'h10000);
            exp_q.push_back(w);
        end else begin
            w = (32'd15 << 26) | (32'(rt) << 16) | (v / 32'h10000);
            exp_q.push_back(w);
            w = (32'd13 << 26) | (32'(rt) << 21) | (32'(rt) << 16) | (v % 32'h10000);
            exp_q.push_back(w);
        end
    endfunction

    task automatic check_outputs(input string tag, input logic [31:0] w, input logic lst);
        check({tag, ".valid"}, 64'(bus.instr_valid_o), 64'd1);
        check({tag, ".instr"}, 64'(bus.instr_o), 64'(w));
        check({tag, ".last"},  64'(bus.last_o), 64'(lst));
        check({tag, ".rdy"},   64'(bus.req_ready_o), 64'd0);
    endtask

    // One request; stall_at selects which instruction gets max_stall wait cycles (-1: random)
    task automatic send(input logic [4:0] rt, input logic [31:0] v, input int max_stall, input int stall_at);
        int stalls;
        @(negedge clk_i);
        check("pre.req_ready", 64'(bus.req_ready_o), 64'd1);
        bus.req_valid_i   = 1'b1;
        bus.rt_i          = rt;
        bus.value_i       = v;
        bus.instr_ready_i = 1'b1;
        @(negedge clk_i);
        bus.req_valid_i = 1'b0;
        bus.value_i     = $urandom;
        if (rt == 5'd0) begin
            check("drop.valid", 64'(bus.instr_valid_o), 64'd0);
            check("drop.ready", 64'(bus.req_ready_o), 64'd1);
            check("drop.cnt",   64'(instr_cnt_o), 64'(cnt_exp));
            return;
        end
        model(rt, v);
        for (int k = 0; k < exp_q.size(); k++) begin
            logic lst;
            lst = (k == exp_q.size() - 1);
            if (stall_at < 0) stalls = $urandom_range(0, max_stall);
            else stalls = (k == stall_at) ? max_stall : 0;
            for (int s = 0; s < stalls; s++) begin
                bus.instr_ready_i = 1'b0;
                check_outputs("stall", exp_q[k], lst);
                @(negedge clk_i);
            end
            bus.instr_ready_i = 1'b1;
            check_outputs("emit", exp_q[k], lst);
            @(negedge clk_i);
            cnt_exp = (cnt_exp + 1) % 65536;
        end
        bus.instr_ready_i = $urandom_range(0, 1);
        check("done.valid", 64'(bus.instr_valid_o), 64'd0);
        check("done.ready", 64'(bus.req_ready_o), 64'd1);
        check("done.cnt",   64'(instr_cnt_o), 64'(cnt_exp));
        check("done.err",   64'(err_o), 64'd0);
    endtask

    initial begin
        logic [31:0] v;
        logic [4:0]  rt;
        int          cat;
        n_pass  = 0;
        n_total = 0;
        cnt_exp = 0;
        bus.req_valid_i   = 1'b0;
        bus.rt_i          = 5'd0;
        bus.value_i       = 32'h0;
        bus.instr_ready_i = 1'b0;
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        check("rst.ready", 64'(bus.req_ready_o), 64'd1);
        check("rst.valid", 64'(bus.instr_valid_o), 64'd0);
        check("rst.instr", 64'(bus.instr_o), 64'd0);
        check("rst.last",  64'(bus.last_o), 64'd0);
        check("rst.cnt",   64'(instr_cnt_o), 64'd0);
        check("rst.err",   64'(err_o), 64'd0);
        rst_i = 1'b0;

        send(5'd8,  32'hFFFFFFFC, 0, -1);
        check("dir.addi", 64'(32'h2008FFFC), 64'(exp_q[0]));
        send(5'd11, 32'h00008000, 0, -1);
        send(5'd9,  32'h00010000, 0, -1);
        send(5'd10, 32'h12345678, 3, 1);
        send(5'd0,  32'h12345678, 0, -1);
        send(5'd12, 32'h00007FFF, 2, 0);
        send(5'd13, 32'hFFFF8000, 0, -1);
        send(5'd14, 32'hFFFF7FFF, 1, -1);

        // Reset during the ORI of a pair
        @(negedge clk_i);
        bus.req_valid_i   = 1'b1;
        bus.rt_i          = 5'd10;
        bus.value_i       = 32'h12345678;
        bus.instr_ready_i = 1'b1;
        @(negedge clk_i);
        bus.req_valid_i = 1'b0;
        check("rstmid.lui", 64'(bus.instr_o), 64'(32'h3C0A1234));
        @(negedge clk_i);
        bus.instr_ready_i = 1'b0;
        check("rstmid.ori", 64'(bus.instr_o), 64'(32'h354A5678));
        #1 rst_i = 1'b1;
        #1;
        check("rstmid.valid", 64'(bus.instr_valid_o), 64'd0);
        check("rstmid.ready", 64'(bus.req_ready_o), 64'd1);
        check("rstmid.instr", 64'(bus.instr_o), 64'd0);
        check("rstmid.last",  64'(bus.last_o), 64'd0);
        check("rstmid.cnt",   64'(instr_cnt_o), 64'd0);
        check("rstmid.err",   64'(err_o), 64'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        cnt_exp = 0;
        @(negedge clk_i);
        check("rstmid.idle", 64'(bus.instr_valid_o), 64'd0);
        send(5'd10, 32'h12345678, 0, -1);

        for (int i = 0; i < 60; i++) begin
            cat = $urandom_range(0, 4);
            rt  = 5'($urandom_range(0, 31));
            case (cat)
                0: v = {{17{1'($urandom_range(0, 1))}}, 15'($urandom)};
                1: v = {16'h0000, 1'b1, 15'($urandom)};
                2: v = {16'($urandom_range(1, 65535)), 16'h0000};
                default: v = $urandom;
            endcase
            send(rt, v, 3, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
